// File: rtl/register_file.sv
// RV32 integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module register_file #(
  parameter int WIDTH   = 32,
  parameter int NR_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [4:0]       rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  input  logic [4:0]       rs1_addr,
  output logic [WIDTH-1:0] rs1_data,
  input  logic [4:0]       rs2_addr,
  output logic [WIDTH-1:0] rs2_data
);

  localparam int         AW       = $clog2(NR_REGS);
  localparam logic [5:0] NR_LIMIT = 6'(NR_REGS);

  logic [WIDTH-1:0] regs [NR_REGS];
  logic             write_hit;
  logic             fwd1;
  logic             fwd2;

  // An index is backed by storage only when it is nonzero and implemented.
  function automatic logic in_range(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NR_LIMIT);
  endfunction

  assign write_hit = wen && !rst && in_range(rd_addr);

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = write_hit && (rs1_addr == rd_addr);
  assign fwd2 = write_hit && (rs2_addr == rd_addr);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[rd_addr[AW-1:0]] <= rd_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (fwd1) begin
      rs1_data = rd_data;
    end else if (in_range(rs1_addr)) begin
      rs1_data = regs[rs1_addr[AW-1:0]];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (fwd2) begin
      rs2_data = rd_data;
    end else if (in_range(rs2_addr)) begin
      rs2_data = regs[rs2_addr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps plus randomized traffic against an array model,
// driving a 32-entry and a 16-entry instance from the same stimulus.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data32, rs2_data32;
  logic [31:0] rs1_data16, rs2_data16;

  logic [31:0] model [32];
  int checks = 0;
  int errors = 0;

  register_file #(.WIDTH(32), .NR_REGS(32)) dut32 (
    .clk(clk), .rst(rst), .wen(wen), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data32), .rs2_addr(rs2_addr), .rs2_data(rs2_data32)
  );

  register_file #(.WIDTH(32), .NR_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .wen(wen), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data16), .rs2_addr(rs2_addr), .rs2_data(rs2_data16)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Architectural view: what a read of address a must return for an nr-entry file right now.
  function automatic logic [31:0] expect_read(input int nr, input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= nr) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wen && !rst && rd_addr == a) return rd_data;
`endif
    return model[a];
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endfunction

  // Called right after a rising edge with the inputs that were sampled there.
  function automatic void commit_edge();
    if (wen && !rst && rd_addr != 5'd0) model[rd_addr] = rd_data;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_ports(input string tag);
    check_value({tag, "_rs1_32"}, rs1_data32, expect_read(32, rs1_addr));
    check_value({tag, "_rs2_32"}, rs2_data32, expect_read(32, rs2_addr));
    check_value({tag, "_rs1_16"}, rs1_data16, expect_read(16, rs1_addr));
    check_value({tag, "_rs2_16"}, rs2_data16, expect_read(16, rs2_addr));
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input logic en);
    @(negedge clk);
    wen = en; rd_addr = a; rd_data = d;
    @(posedge clk);
    commit_edge();
    #1;
    wen = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    rs1_addr = a1; rs2_addr = a2;
    #1;
    check_ports(tag);
  endtask

  task automatic sweep_all(input string tag);
    for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i), tag);
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
    clear_model();
    #2;
    sweep_all("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    // Reset clears contents asynchronously, without a clock edge.
    write_reg(5'd5, 32'hDEADBEEF, 1'b1);
    read_pair(5'd5, 5'd5, "x5_written");
    check_value("x5_literal", rs1_data32, 32'hDEADBEEF);
    rst = 1'b1;
    clear_model();
    #1;
    check_value("async_clear_x5", rs1_data32, 32'h0);
    rst = 1'b0;
    sweep_all("after_reset");

    write_reg(5'd3, 32'h12345678, 1'b1);
    read_pair(5'd3, 5'd3, "basic_x3");
    check_value("basic_x3_literal", rs2_data32, 32'h12345678);
    read_pair(5'd4, 5'd3, "basic_x4");

    write_reg(5'd0, 32'hFFFFFFFF, 1'b1);
    read_pair(5'd0, 5'd3, "x0_protect");
    check_value("x0_literal", rs1_data32, 32'h0);

    write_reg(5'd7, 32'hA5A5A5A5, 1'b0);
    read_pair(5'd7, 5'd7, "wen_gate");
    check_value("wen_gate_literal", rs1_data32, 32'h0);

    // Same-cycle write/read hazard on x9.
    write_reg(5'd9, 32'h11, 1'b1);
    @(negedge clk);
    wen = 1'b1; rd_addr = 5'd9; rd_data = 32'h22; rs1_addr = 5'd9; rs2_addr = 5'd3;
    #1;
    check_ports("hazard_pre");
`ifdef REGFILE_BYPASS_EN
    check_value("hazard_pre_literal", rs1_data32, 32'h22);
`else
    check_value("hazard_pre_literal", rs1_data32, 32'h11);
`endif
    @(posedge clk);
    commit_edge();
    #1;
    wen = 1'b0;
    #1;
    check_value("hazard_post_literal", rs1_data32, 32'h22);

    // Reset asserted mid-cycle with a pending write: reset wins across the edge.
    @(negedge clk);
    wen = 1'b1; rd_addr = 5'd4; rd_data = 32'hCAFEF00D;
    #1 rst = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    read_pair(5'd4, 5'd9, "reset_vs_write");
    @(negedge clk);
    wen = 1'b0; rst = 1'b0;
    #1;
    read_pair(5'd4, 5'd3, "reset_vs_write_after");

    // Full sweep: x[i] = i * 0x01010101.
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101, 1'b1);
    sweep_all("sweep");
    read_pair(5'd20, 5'd15, "sweep_pick");
    check_value("sweep_x20_32", rs1_data32, 32'h14141414);
    check_value("sweep_x20_16", rs1_data16, 32'h0);
    check_value("sweep_x15_16", rs2_data16, 32'h0F0F0F0F);

    // Randomized traffic, occasionally interrupted by an asynchronous reset.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      wen      = 1'($urandom_range(0, 3) != 0);
      rd_addr  = 5'($urandom_range(0, 31));
      rd_data  = $urandom;
      rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      #1;
      check_ports("rand_pre");
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        clear_model();
        #1;
        check_ports("rand_rst");
      end
      @(posedge clk);
      commit_edge();
      #1;
      check_ports("rand_post");
      rst = 1'b0;
    end

    wen = 1'b0;
    #1;
    sweep_all("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose integer register file for the RV32 core: 32 architectural registers, two combinational read ports, one synchronous write port.
- Read ports serve operand fetch in the decode stage.
- The write port is driven by the write-back stage, which gates `wen` with its own valid/new-data qualifier.
- Register x0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width in bits of each register and of all data ports.
- NR_REGS, 32, number of implemented registers; legal values 16 (RV32E) or 32. Address port width stays 5 bits regardless.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst  input  1  asynchronous reset, active-high.
- wen  input  1  write enable, sampled at rising clk.
- rd_addr  input  5  destination register index.
- rd_data  input  WIDTH  write data.
- rs1_addr  input  5  read port 1 index.
- rs1_data  output  WIDTH  read port 1 data, combinational.
- rs2_addr  input  5  read port 2 index.
- rs2_data  output  WIDTH  read port 2 data, combinational.

Interface note: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Storage: NR_REGS entries of WIDTH bits. Entry 0 may be omitted from storage.
- Reset:
  - While rst=1, all entries are 0, applied asynchronously on the rst rising edge, independent of clk.
  - rs1_data/rs2_data therefore read 0 for every address during and right after reset.
  - Writes are ignored while rst=1, including when wen=1 at a clk edge.
- Write:
  - At posedge clk with rst=0, wen=1, rd_addr!=0 and rd_addr<NR_REGS: entry[rd_addr] <= rd_data.
  - Any other case leaves all entries unchanged.
  - One write per cycle; latency 1 cycle (visible on read ports after the edge).
- x0: rd_addr=0 writes are silently discarded; reading index 0 always returns 0.
- Out-of-range index (NR_REGS=16, index 16..31): writes discarded; reads return 0.
- Read:
  - Purely combinational: rsN_data = entry[rsN_addr], or 0 per the rules above.
  - Both ports are independent and may address the same register.
- Same-cycle read/write of the same index, without the optional feature: the read returns the old value until the clock edge, the new value after it.
- Reset asserted mid-cycle while wen=1: reset wins; contents go to 0 immediately and the pending write is lost.
- No X propagation: outputs are always defined after the first reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If wen=1, rst=0, rd_addr!=0, rd_addr in range and rsN_addr==rd_addr, then rsN_data = rd_data combinationally in the same cycle.
  - Applies per port independently.
  - Storage update at the edge is unchanged.
- Undefined: no forwarding; same-cycle reads return stored contents as specified under Behaviour.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, pulse rst between clock edges -> rs1_data for x5 reads 0 immediately without any clk edge; all 32 indices read 0.
- Basic write/read: wen=1, rd_addr=3, rd_data=0x12345678, one edge -> rs1_addr=3 and rs2_addr=3 both read 0x12345678; x4 still 0.
- x0 protection: wen=1, rd_addr=0, rd_data=0xFFFFFFFF -> rs1_addr=0 reads 0 after the edge; no other register changes.
- wen gating: wen=0, rd_addr=7, rd_data=0xA5A5A5A5 -> x7 keeps its previous value 0 after the edge.
- Same-cycle hazard: x9=0x11, then wen=1, rd_addr=9, rd_data=0x22 with rs1_addr=9 before the edge:
  - without REGFILE_BYPASS_EN -> 0x11 before the edge, 0x22 after;
  - with it -> 0x22 before the edge.
- Full sweep and NR_REGS=16: write i*0x01010101 to each x1..x31, read back on both ports -> exact values. With NR_REGS=16, indices 16..31 read 0 after the same writes.
